riscv_pipeline_cpu: RTL and testbench
=====================================

// Module: riscv_pipeline_cpu
// PURPOSE
//  Top-level 5-stage (IF/ID/EX/MEM/WB) in-order RV32 subset core with its own instruction memory, data memory and register file.
//  Resolves data hazards by EX forwarding plus a load-use stall. Resolves beq in ID with a 1-cycle flush (predict not-taken).
//  Sits alone under the bench. Program and data are preloaded hierarchically; the core only needs a clock and a start.
// PARAMETERS
//  IMEM_WORDS  256  instruction memory depth, 32-bit words
//  DMEM_BYTES  32   data memory depth, bytes
// PORTS
//  clk_i    in  1  clock; all state updates on posedge
//  start_i  in  1  asynchronous active-low reset; 0 = hold in reset, 1 = run
// BEHAVIOUR
//  - Reset (start_i=0, async): PC=0, every pipeline register cleared, IF/ID flush flag=1 (bubble).
//  - Reset does not touch memories or the register file; contents are preloaded by the bench.
//  - Hierarchy the bench pokes and reads:
//    - PC.pc_o, Instruction_Memory.memory[256]x32, Data_Memory.memory[32]x8, Registers.register[32]x32
//    - HDU.Stall_out, HDU.Taken_out
//    - IF/ID: PC_ID, Instruction_ID, Flush_ID
//    - ID/EX: RegWrite_EX, MemWrite_EX, MemRead_EX, ALUSrc_EX, ALUOp_EX, RS1Data_EX, RS2Data_EX, Immediate_EX, RS1Addr_EX, RS2Addr_EX, RDAddr_EX
//    - EX/MEM: RegWrite_MEM, MemWrite_MEM, MemRead_MEM, ALURes_MEM, RS2Data_MEM, RDAddr_MEM
//    - MEM/WB: RegWrite_WB, MemRead_WB, ALURes_WB, MemData_WB, RDAddr_WB
//  - ISA: and, or, add, sub, mul (low 32 bits), addi, lw, sw, beq.
//    - Any other encoding, including all-zero, is a NOP: no register or memory write.
//  - IF: instr = imem[PC[9:2]]. PC += 4 each cycle unless stalled. Index wraps modulo 256.
//  - ID:
//    - Decode and sign-extend immediates (I, S, B types).
//    - Register file: x0 reads 0 and writes to it are dropped. A WB write to the same register is bypassed to the ID read in the same cycle.
//    - beq compares register-file/WB-bypassed values only; there is no EX/MEM forwarding into ID.
//  - beq taken:
//    - Target = PC_ID + (sext(imm_B) << 1).
//    - Next PC = target; the IF/ID instruction is flushed (Flush_ID=1 becomes a bubble).
//    - HDU.Taken_out=1 for exactly that cycle. Penalty is 1 cycle.
//  - Load-use:
//    - Condition: MemRead_EX=1, RDAddr_EX!=0, and RDAddr_EX equals ID rs1 or rs2.
//    - Response: HDU.Stall_out=1, hold PC and IF/ID, insert a bubble into ID/EX. Exactly 1 stall cycle.
//    - Stall takes priority; a branch sitting in ID under a stall is re-evaluated next cycle.
//  - EX forwarding (per operand, both rs1 and rs2, including the sw store data):
//    - Priority 1: EX/MEM when RegWrite_MEM and RDAddr_MEM!=0 and match.
//    - Priority 2: MEM/WB when RegWrite_WB and RDAddr_WB!=0 and match.
//    - Otherwise use the ID/EX value.
//  - ALU: 32-bit two's complement; overflow is ignored.
//  - MEM:
//    - Little-endian 32-bit word access at byte address ALURes_MEM[4:0]; the word spans bytes a..a+3 (mod 32).
//    - sw writes at posedge. lw reads combinationally into MemData_WB.
//  - WB: result = MemRead_WB ? MemData_WB : ALURes_WB; written at posedge when RegWrite_WB.
//  - Latency: an instruction's result is architecturally visible 5 cycles after fetch. Back-to-back ALU dependencies incur no stall.
//  - Reset mid-run: pipeline is squashed immediately. Instructions that already retired keep their register/memory effects.
// TESTING
//  - Reset then addi x1,x0,5; addi x2,x1,3; add x3,x1,x2 -> x1=5, x2=8, x3=13; Stall_out never asserted.
//  - mem[0]=5; lw x1,0(x0); addi x2,x1,1 -> 1 stall cycle counted, x2=6.
//  - addi x1,x0,7; sw x1,4(x0); lw x2,4(x0) -> DMEM 0x04=7, x2=7.
//  - addi x1,x0,1; 2 NOPs; beq x1,x1,+8 over addi x5,x0,9 -> Taken_out pulses once, x5 stays 0.
//  - addi x0,x0,3; sub x4,x0,x1 with x1=2 -> x0=0, x4=0xFFFFFFFE; mul 3*4 -> 12.
//  - Run Fibonacci program with mem[0]=5 for 100 cycles, drop start_i mid-run -> PC=0 next edge, all pipeline regs 0.

Source files
------------

// File: rtl/riscv_pipeline_cpu.sv
// riscv_pipeline_cpu: 5-stage in-order RV32 subset core (and/or/add/sub/mul/addi/lw/sw/beq)
// with EX forwarding, a one-cycle load-use stall and beq resolved in ID.
module riscv_pipeline_cpu #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_BYTES = 32
) (
    input logic clk_i,
    input logic start_i
);
    localparam int IW = $clog2(IMEM_WORDS);
    localparam int DW = $clog2(DMEM_BYTES);
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_MUL} alu_op_e;

    logic [31:0] pc, pc_next, instr_if;
    logic        stall, taken;
    logic [31:0] PC_ID, Instruction_ID;
    logic        Flush_ID;
    logic        RegWrite_EX, MemWrite_EX, MemRead_EX, ALUSrc_EX;
    alu_op_e     ALUOp_EX;
    logic [31:0] RS1Data_EX, RS2Data_EX, Immediate_EX;
    logic [4:0]  RS1Addr_EX, RS2Addr_EX, RDAddr_EX;
    logic        RegWrite_MEM, MemWrite_MEM, MemRead_MEM;
    logic [31:0] ALURes_MEM, RS2Data_MEM;
    logic [4:0]  RDAddr_MEM;
    logic        RegWrite_WB, MemRead_WB;
    logic [31:0] ALURes_WB, MemData_WB;
    logic [4:0]  RDAddr_WB;

    logic [31:0] inst, imm_id, br_off, rs1_val, rs2_val, wb_data, mem_rdata;
    logic [31:0] fwd_a, fwd_b, alu_b, alu_res;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rs1_id, rs2_id;
    logic        r_base, r_add, r_sub, r_and, r_or, r_mul, is_r, is_addi, is_lw, is_sw, is_beq;
    alu_op_e     op_id;

    PC PC (.clk_i(clk_i), .rst_ni(start_i), .stall_i(stall), .pc_i(pc_next), .pc_o(pc));

    Instruction_Memory #(.WORDS(IMEM_WORDS)) Instruction_Memory (
        .clk_i(clk_i), .we_i(1'b0), .addr_i(pc[IW+1:2]), .wdata_i(32'h0), .instr_o(instr_if)
    );

    assign pc_next = taken ? PC_ID + br_off : pc + 32'd4;

    always_ff @(posedge clk_i or negedge start_i)
        if (!start_i) begin
            PC_ID          <= '0;
            Instruction_ID <= '0;
            Flush_ID       <= 1'b1;
        end else if (!stall) begin
            PC_ID          <= pc;
            Instruction_ID <= taken ? '0 : instr_if;
            Flush_ID       <= taken;
        end

    // A flushed slot decodes as all-zero, which is a NOP
    assign inst    = Flush_ID ? '0 : Instruction_ID;
    assign opc     = inst[6:0];
    assign f3      = inst[14:12];
    assign f7      = inst[31:25];
    assign r_base  = opc == 7'b0110011;
    assign r_add   = r_base && f3 == 3'b000 && f7 == 7'b0000000;
    assign r_sub   = r_base && f3 == 3'b000 && f7 == 7'b0100000;
    assign r_mul   = r_base && f3 == 3'b000 && f7 == 7'b0000001;
    assign r_and   = r_base && f3 == 3'b111 && f7 == 7'b0000000;
    assign r_or    = r_base && f3 == 3'b110 && f7 == 7'b0000000;
    assign is_r    = r_add || r_sub || r_mul || r_and || r_or;
    assign is_addi = opc == 7'b0010011 && f3 == 3'b000;
    assign is_lw   = opc == 7'b0000011 && f3 == 3'b010;
    assign is_sw   = opc == 7'b0100011 && f3 == 3'b010;
    assign is_beq  = opc == 7'b1100011 && f3 == 3'b000;
    assign op_id   = r_sub ? ALU_SUB : r_and ? ALU_AND : r_or ? ALU_OR : r_mul ? ALU_MUL : ALU_ADD;
    // Unused source fields read as x0 so they never trigger a hazard or forward
    assign rs1_id  = (is_r || is_addi || is_lw || is_sw || is_beq) ? inst[19:15] : 5'd0;
    assign rs2_id  = (is_r || is_sw || is_beq) ? inst[24:20] : 5'd0;
    assign imm_id  = is_sw ? {{20{inst[31]}}, inst[31:25], inst[11:7]} : {{20{inst[31]}}, inst[31:20]};
    assign br_off  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};

    Registers Registers (
        .clk_i(clk_i), .we_i(RegWrite_WB), .rs1_i(rs1_id), .rs2_i(rs2_id), .rd_i(RDAddr_WB),
        .wd_i(wb_data), .rs1_data_o(rs1_val), .rs2_data_o(rs2_val)
    );

    HDU HDU (
        .MemRead_EX_i(MemRead_EX), .RDAddr_EX_i(RDAddr_EX), .rs1_i(rs1_id), .rs2_i(rs2_id),
        .beq_i(is_beq), .eq_i(rs1_val == rs2_val), .Stall_out(stall), .Taken_out(taken)
    );

    always_ff @(posedge clk_i or negedge start_i)
        if (!start_i) begin
            {RegWrite_EX, MemWrite_EX, MemRead_EX, ALUSrc_EX} <= '0;
            ALUOp_EX <= ALU_ADD;
            {RS1Data_EX, RS2Data_EX, Immediate_EX} <= '0;
            {RS1Addr_EX, RS2Addr_EX, RDAddr_EX} <= '0;
        end else begin
            RegWrite_EX  <= !stall && (is_r || is_addi || is_lw);
            MemWrite_EX  <= !stall && is_sw;
            MemRead_EX   <= !stall && is_lw;
            ALUSrc_EX    <= is_addi || is_lw || is_sw;
            ALUOp_EX     <= op_id;
            RS1Data_EX   <= rs1_val;
            RS2Data_EX   <= rs2_val;
            Immediate_EX <= imm_id;
            RS1Addr_EX   <= rs1_id;
            RS2Addr_EX   <= rs2_id;
            RDAddr_EX    <= inst[11:7];
        end

    assign wb_data = MemRead_WB ? MemData_WB : ALURes_WB;
    assign fwd_a = (RegWrite_MEM && RDAddr_MEM != 5'd0 && RDAddr_MEM == RS1Addr_EX) ? ALURes_MEM :
                   (RegWrite_WB && RDAddr_WB != 5'd0 && RDAddr_WB == RS1Addr_EX) ? wb_data : RS1Data_EX;
    assign fwd_b = (RegWrite_MEM && RDAddr_MEM != 5'd0 && RDAddr_MEM == RS2Addr_EX) ? ALURes_MEM :
                   (RegWrite_WB && RDAddr_WB != 5'd0 && RDAddr_WB == RS2Addr_EX) ? wb_data : RS2Data_EX;
    assign alu_b = ALUSrc_EX ? Immediate_EX : fwd_b;
    assign alu_res = (ALUOp_EX == ALU_SUB) ? fwd_a - alu_b :
                     (ALUOp_EX == ALU_AND) ? fwd_a & alu_b :
                     (ALUOp_EX == ALU_OR)  ? fwd_a | alu_b :
                     (ALUOp_EX == ALU_MUL) ? fwd_a * alu_b : fwd_a + alu_b;

    always_ff @(posedge clk_i or negedge start_i)
        if (!start_i) begin
            {RegWrite_MEM, MemWrite_MEM, MemRead_MEM} <= '0;
            {ALURes_MEM, RS2Data_MEM} <= '0;
            RDAddr_MEM <= '0;
        end else begin
            RegWrite_MEM <= RegWrite_EX;
            MemWrite_MEM <= MemWrite_EX;
            MemRead_MEM  <= MemRead_EX;
            ALURes_MEM   <= alu_res;
            RS2Data_MEM  <= fwd_b;
            RDAddr_MEM   <= RDAddr_EX;
        end

    Data_Memory #(.BYTES(DMEM_BYTES)) Data_Memory (
        .clk_i(clk_i), .we_i(MemWrite_MEM), .addr_i(ALURes_MEM[DW-1:0]),
        .wdata_i(RS2Data_MEM), .rdata_o(mem_rdata)
    );

    always_ff @(posedge clk_i or negedge start_i)
        if (!start_i) begin
            {RegWrite_WB, MemRead_WB} <= '0;
            {ALURes_WB, MemData_WB} <= '0;
            RDAddr_WB <= '0;
        end else begin
            RegWrite_WB <= RegWrite_MEM;
            MemRead_WB  <= MemRead_MEM;
            ALURes_WB   <= ALURes_MEM;
            MemData_WB  <= mem_rdata;
            RDAddr_WB   <= RDAddr_MEM;
        end
endmodule

module PC (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic [31:0] pc_i,
    output logic [31:0] pc_o
);
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) pc_o <= '0;
        else if (!stall_i) pc_o <= pc_i;
endmodule

module Instruction_Memory #(
    parameter int WORDS = 256
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(WORDS)-1:0] addr_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              instr_o
);
    logic [31:0] memory [WORDS];
    always_ff @(posedge clk_i)
        if (we_i) memory[addr_i] <= wdata_i;
    assign instr_o = memory[addr_i];
endmodule

module Data_Memory #(
    parameter int BYTES = 32
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(BYTES)-1:0] addr_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o
);
    localparam int AW = $clog2(BYTES);
    logic [7:0] memory [BYTES];
    // Little-endian word; byte indices wrap around the array
    always_ff @(posedge clk_i)
        if (we_i)
            for (int i = 0; i < 4; i++) memory[addr_i + AW'(i)] <= wdata_i[8*i +: 8];
    always_comb
        for (int i = 0; i < 4; i++) rdata_o[8*i +: 8] = memory[addr_i + AW'(i)];
endmodule

module Registers (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o
);
    logic [31:0] register [32];
    always_ff @(posedge clk_i)
        if (we_i && rd_i != 5'd0) register[rd_i] <= wd_i;
    assign rs1_data_o = (rs1_i == 5'd0) ? '0 : (we_i && rd_i == rs1_i) ? wd_i : register[rs1_i];
    assign rs2_data_o = (rs2_i == 5'd0) ? '0 : (we_i && rd_i == rs2_i) ? wd_i : register[rs2_i];
endmodule

module HDU (
    input  logic       MemRead_EX_i,
    input  logic [4:0] RDAddr_EX_i,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic       beq_i,
    input  logic       eq_i,
    output logic       Stall_out,
    output logic       Taken_out
);
    assign Stall_out = MemRead_EX_i && RDAddr_EX_i != 5'd0 && (RDAddr_EX_i == rs1_i || RDAddr_EX_i == rs2_i);
    // A stalled branch is re-evaluated once its operands settle
    assign Taken_out = beq_i && eq_i && !Stall_out;
endmodule

// File: tb/tb_riscv_pipeline_cpu.sv
// tb_riscv_pipeline_cpu: randomized and directed programs checked against an
// instruction-level interpreter of the RV32 subset.
module tb_riscv_pipeline_cpu;
    logic clk_i = 1'b0;
    logic start_i = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    int stalls, takens;

    riscv_pipeline_cpu dut (.clk_i(clk_i), .start_i(start_i));

    always #5 clk_i = ~clk_i;

    typedef enum int {K_ADD, K_SUB, K_AND, K_OR, K_MUL, K_ADDI, K_LW, K_SW, K_NOP} kind_e;
    typedef struct {kind_e k; int rd; int rs1; int rs2; int imm;} ins_t;

    ins_t        prog[$];
    logic [31:0] m_reg [32];
    logic [7:0]  m_mem [32];

    function automatic ins_t mk(input kind_e k, input int rd, input int rs1, input int rs2, input int imm);
        ins_t i;
        i.k = k; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.imm = imm;
        return i;
    endfunction

    function automatic logic [31:0] enc(input ins_t i);
        logic [4:0]  rd = 5'(i.rd);
        logic [4:0]  a = 5'(i.rs1);
        logic [4:0]  b = 5'(i.rs2);
        logic [11:0] im = 12'(i.imm);
        case (i.k)
            K_ADD:   return {7'h00, b, a, 3'b000, rd, 7'h33};
            K_SUB:   return {7'h20, b, a, 3'b000, rd, 7'h33};
            K_AND:   return {7'h00, b, a, 3'b111, rd, 7'h33};
            K_OR:    return {7'h00, b, a, 3'b110, rd, 7'h33};
            K_MUL:   return {7'h01, b, a, 3'b000, rd, 7'h33};
            K_ADDI:  return {im, a, 3'b000, rd, 7'h13};
            K_LW:    return {im, a, 3'b010, rd, 7'h03};
            K_SW:    return {im[11:5], b, a, 3'b010, im[4:0], 7'h23};
            default: return (i.imm & 1) != 0 ? {7'h02, b, a, 3'b000, rd, 7'h33} : 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] enc_beq(input int rs1, input int rs2, input int off);
        logic [12:0] o = 13'(off);
        return {o[12], o[10:5], 5'(rs2), 5'(rs1), 3'b000, o[4:1], o[11], 7'h63};
    endfunction

    function automatic void model_exec(input ins_t i);
        logic [31:0] a = m_reg[i.rs1];
        logic [31:0] b = m_reg[i.rs2];
        logic [31:0] r = 32'h0;
        int ad = int'((a + 32'(i.imm)) & 32'h1f);
        case (i.k)
            K_ADD:  r = a + b;
            K_SUB:  r = a - b;
            K_AND:  r = a & b;
            K_OR:   r = a | b;
            K_MUL:  r = a * b;
            K_ADDI: r = a + 32'(i.imm);
            K_LW:   for (int j = 0; j < 4; j++) r[8*j +: 8] = m_mem[(ad + j) % 32];
            K_SW:   for (int j = 0; j < 4; j++) m_mem[(ad + j) % 32] = b[8*j +: 8];
            default: ;
        endcase
        if (i.k inside {K_ADD, K_SUB, K_AND, K_OR, K_MUL, K_ADDI, K_LW} && i.rd != 0) m_reg[i.rd] = r;
    endfunction

    function automatic logic [511:0] pipe_state();
        return 512'({dut.PC_ID, dut.Instruction_ID,
                     dut.RegWrite_EX, dut.MemWrite_EX, dut.MemRead_EX, dut.ALUSrc_EX, dut.ALUOp_EX,
                     dut.RS1Data_EX, dut.RS2Data_EX, dut.Immediate_EX, dut.RS1Addr_EX, dut.RS2Addr_EX, dut.RDAddr_EX,
                     dut.RegWrite_MEM, dut.MemWrite_MEM, dut.MemRead_MEM, dut.ALURes_MEM, dut.RS2Data_MEM, dut.RDAddr_MEM,
                     dut.RegWrite_WB, dut.MemRead_WB, dut.ALURes_WB, dut.MemData_WB, dut.RDAddr_WB});
    endfunction

    function automatic logic [31:0] dmem_word(input int a);
        return {dut.Data_Memory.memory[(a + 3) % 32], dut.Data_Memory.memory[(a + 2) % 32],
                dut.Data_Memory.memory[(a + 1) % 32], dut.Data_Memory.memory[a % 32]};
    endfunction

    task automatic reset_and_clear();
        start_i = 1'b0;
        #1;
        for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] <= 32'h0;
        for (int i = 0; i < 32; i++) begin
            dut.Data_Memory.memory[i] <= 8'h0;
            dut.Registers.register[i] <= 32'h0;
            m_reg[i] = 32'h0;
            m_mem[i] = 8'h0;
        end
        #1;
    endtask

    task automatic load_prog();
        for (int n = 0; n < prog.size(); n++) dut.Instruction_Memory.memory[n] <= enc(prog[n]);
    endtask

    task automatic run(input int cycles);
        stalls = 0;
        takens = 0;
        @(negedge clk_i);
        start_i = 1'b1;
        repeat (cycles) begin
            @(negedge clk_i);
            stalls += int'(dut.HDU.Stall_out);
            takens += int'(dut.HDU.Taken_out);
        end
    endtask

    task automatic test_reset();
        start_i = 1'b1;
        #1 start_i = 1'b0;
        #1;
        n_cmp++; if (dut.PC.pc_o !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", dut.PC.pc_o); end
        n_cmp++; if (dut.Flush_ID !== 1'b1) begin n_err++; $display("FAIL reset_flush got %b want 1", dut.Flush_ID); end
        n_cmp++; if (pipe_state() !== 512'h0) begin n_err++; $display("FAIL reset_pipe got %h want 0", pipe_state()); end
        @(posedge clk_i); #1;
        n_cmp++; if (dut.PC.pc_o !== 32'h0) begin n_err++; $display("FAIL reset_hold_pc got %h want 0", dut.PC.pc_o); end
    endtask

    task automatic test_alu_chain();
        reset_and_clear();
        prog = {mk(K_ADDI, 1, 0, 0, 5), mk(K_ADDI, 2, 1, 0, 3), mk(K_ADD, 3, 1, 2, 0)};
        load_prog();
        run(12);
        n_cmp++; if (dut.Registers.register[1] !== 32'd5) begin n_err++; $display("FAIL chain_x1 got %0d want 5", dut.Registers.register[1]); end
        n_cmp++; if (dut.Registers.register[2] !== 32'd8) begin n_err++; $display("FAIL chain_x2 got %0d want 8", dut.Registers.register[2]); end
        n_cmp++; if (dut.Registers.register[3] !== 32'd13) begin n_err++; $display("FAIL chain_x3 got %0d want 13", dut.Registers.register[3]); end
        n_cmp++; if (stalls !== 0) begin n_err++; $display("FAIL chain_stalls got %0d want 0", stalls); end
    endtask

    task automatic test_load_use();
        reset_and_clear();
        dut.Data_Memory.memory[0] <= 8'd5;
        prog = {mk(K_LW, 1, 0, 0, 0), mk(K_ADDI, 2, 1, 0, 1)};
        load_prog();
        run(12);
        n_cmp++; if (stalls !== 1) begin n_err++; $display("FAIL loaduse_stalls got %0d want 1", stalls); end
        n_cmp++; if (dut.Registers.register[1] !== 32'd5) begin n_err++; $display("FAIL loaduse_x1 got %0d want 5", dut.Registers.register[1]); end
        n_cmp++; if (dut.Registers.register[2] !== 32'd6) begin n_err++; $display("FAIL loaduse_x2 got %0d want 6", dut.Registers.register[2]); end
    endtask

    task automatic test_store_load();
        reset_and_clear();
        prog = {mk(K_ADDI, 1, 0, 0, 7), mk(K_SW, 0, 0, 1, 4), mk(K_LW, 2, 0, 0, 4)};
        load_prog();
        run(12);
        n_cmp++; if (dmem_word(4) !== 32'd7) begin n_err++; $display("FAIL store_mem4 got %h want 7", dmem_word(4)); end
        n_cmp++; if (dut.Registers.register[2] !== 32'd7) begin n_err++; $display("FAIL store_x2 got %0d want 7", dut.Registers.register[2]); end
    endtask

    task automatic test_branch();
        for (int t = 0; t < 2; t++) begin
            reset_and_clear();
            prog = {mk(K_ADDI, 1, 0, 0, 1), mk(K_NOP, 0, 0, 0, 0), mk(K_NOP, 0, 0, 0, 0)};
            load_prog();
            dut.Instruction_Memory.memory[3] <= enc_beq(1, t == 0 ? 1 : 0, 8);
            dut.Instruction_Memory.memory[4] <= enc(mk(K_ADDI, 5, 0, 0, 9));
            dut.Instruction_Memory.memory[5] <= enc(mk(K_ADDI, 6, 0, 0, 4));
            run(14);
            n_cmp++; if (takens !== (t == 0 ? 1 : 0)) begin n_err++; $display("FAIL branch%0d_taken got %0d want %0d", t, takens, t == 0 ? 1 : 0); end
            n_cmp++; if (dut.Registers.register[5] !== (t == 0 ? 32'd0 : 32'd9)) begin n_err++; $display("FAIL branch%0d_x5 got %0d", t, dut.Registers.register[5]); end
            n_cmp++; if (dut.Registers.register[6] !== 32'd4) begin n_err++; $display("FAIL branch%0d_x6 got %0d want 4", t, dut.Registers.register[6]); end
        end
    endtask

    task automatic test_x0_sub_mul();
        reset_and_clear();
        dut.Registers.register[1] <= 32'd2;
        dut.Registers.register[2] <= 32'd3;
        dut.Registers.register[3] <= 32'd4;
        prog = {mk(K_ADDI, 0, 0, 0, 3), mk(K_SUB, 4, 0, 1, 0), mk(K_MUL, 6, 2, 3, 0)};
        load_prog();
        run(12);
        n_cmp++; if (dut.Registers.register[0] !== 32'd0) begin n_err++; $display("FAIL x0_write got %h want 0", dut.Registers.register[0]); end
        n_cmp++; if (dut.Registers.register[4] !== 32'hFFFFFFFE) begin n_err++; $display("FAIL sub_x4 got %h want fffffffe", dut.Registers.register[4]); end
        n_cmp++; if (dut.Registers.register[6] !== 32'd12) begin n_err++; $display("FAIL mul_x6 got %0d want 12", dut.Registers.register[6]); end
    endtask

    task automatic test_random();
        for (int p = 0; p < 8; p++) begin
            int exp_stalls = 0;
            reset_and_clear();
            for (int r = 1; r < 32; r++) begin m_reg[r] = $urandom; dut.Registers.register[r] <= m_reg[r]; end
            for (int b = 0; b < 32; b++) begin m_mem[b] = 8'($urandom); dut.Data_Memory.memory[b] <= m_mem[b]; end
            prog = {};
            for (int n = 0; n < 40; n++)
                prog.push_back(mk(kind_e'($urandom_range(0, 8)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                                  int'($urandom_range(0, 7)), int'($urandom_range(0, 4095)) - 2048));
            load_prog();
            foreach (prog[n]) model_exec(prog[n]);
            for (int n = 0; n + 1 < prog.size(); n++)
                if (prog[n].k == K_LW && prog[n].rd != 0 &&
                    ((prog[n+1].k != K_NOP && prog[n+1].rs1 == prog[n].rd) ||
                     (prog[n+1].k inside {K_ADD, K_SUB, K_AND, K_OR, K_MUL, K_SW} && prog[n+1].rs2 == prog[n].rd)))
                    exp_stalls++;
            run(100);
            for (int r = 1; r < 32; r++) begin
                n_cmp++;
                if (dut.Registers.register[r] !== m_reg[r]) begin n_err++; $display("FAIL rand%0d_x%0d got %h want %h", p, r, dut.Registers.register[r], m_reg[r]); end
            end
            for (int b = 0; b < 32; b++) begin
                n_cmp++;
                if (dut.Data_Memory.memory[b] !== m_mem[b]) begin n_err++; $display("FAIL rand%0d_mem%0d got %h want %h", p, b, dut.Data_Memory.memory[b], m_mem[b]); end
            end
            n_cmp++; if (stalls !== exp_stalls) begin n_err++; $display("FAIL rand%0d_stalls got %0d want %0d", p, stalls, exp_stalls); end
            n_cmp++; if (takens !== 0) begin n_err++; $display("FAIL rand%0d_taken got %0d want 0", p, takens); end
        end
    endtask

    task automatic test_fib_reset();
        logic [31:0] fa = 32'd0, fb = 32'd1, ft;
        reset_and_clear();
        dut.Data_Memory.memory[0] <= 8'd5;
        prog = {mk(K_LW, 1, 0, 0, 0), mk(K_ADDI, 2, 0, 0, 0), mk(K_ADDI, 3, 0, 0, 1), mk(K_ADDI, 4, 0, 0, 0),
                mk(K_NOP, 0, 0, 0, 0), mk(K_NOP, 0, 0, 0, 0), mk(K_NOP, 0, 0, 0, 0),
                mk(K_ADD, 5, 2, 3, 0), mk(K_ADD, 2, 3, 0, 0), mk(K_ADD, 3, 5, 0, 0), mk(K_ADDI, 4, 4, 0, 1),
                mk(K_NOP, 0, 0, 0, 0), mk(K_NOP, 0, 0, 0, 0), mk(K_SW, 0, 0, 2, 4)};
        load_prog();
        dut.Instruction_Memory.memory[6]  <= enc_beq(4, 1, 28);
        dut.Instruction_Memory.memory[12] <= enc_beq(0, 0, -24);
        dut.Instruction_Memory.memory[14] <= enc_beq(0, 0, 0);
        for (int n = 0; n < 5; n++) begin ft = fa + fb; fa = fb; fb = ft; end
        run(100);
        n_cmp++; if (dmem_word(4) !== fa) begin n_err++; $display("FAIL fib_mem4 got %0d want %0d", dmem_word(4), fa); end
        n_cmp++; if (dut.Registers.register[3] !== fb) begin n_err++; $display("FAIL fib_x3 got %0d want %0d", dut.Registers.register[3], fb); end
        #2 start_i = 1'b0;
        #1;
        n_cmp++; if (dut.PC.pc_o !== 32'h0) begin n_err++; $display("FAIL fib_squash_pc got %h want 0", dut.PC.pc_o); end
        n_cmp++; if (dut.Flush_ID !== 1'b1) begin n_err++; $display("FAIL fib_squash_flush got %b want 1", dut.Flush_ID); end
        n_cmp++; if (pipe_state() !== 512'h0) begin n_err++; $display("FAIL fib_squash_pipe got %h want 0", pipe_state()); end
        @(posedge clk_i); #1;
        n_cmp++; if (dut.PC.pc_o !== 32'h0) begin n_err++; $display("FAIL fib_edge_pc got %h want 0", dut.PC.pc_o); end
        n_cmp++; if (dut.Registers.register[2] !== fa) begin n_err++; $display("FAIL fib_kept_x2 got %0d want %0d", dut.Registers.register[2], fa); end
        n_cmp++; if (dmem_word(4) !== fa) begin n_err++; $display("FAIL fib_kept_mem got %0d want %0d", dmem_word(4), fa); end
    endtask

    initial begin
        test_reset();
        test_alu_chain();
        test_load_use();
        test_store_load();
        test_branch();
        test_x0_sub_mul();
        test_random();
        test_fib_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of tests");
        $fatal(1);
    end
endmodule
